store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/sb_pkg.sv | 14 +
 rtl/sb_fifo.sv | 48 ++++
 rtl/store_buffer.sv | 159 +++++++++++++++
 tb/tb_store_buffer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Store buffer shared constants: memory
// commands and control FSM states.
package sb_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_WRITE = 2'b01;
  localparam logic [1:0] MEM_READ  = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    FENCE = 1'b1
  } sb_state_e;

endpackage

// File: rtl/sb_fifo.sv
// Store buffer FIFO: entry storage, head/tail
// pointers and occupancy count.
module sb_fifo
  import sb_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = 12,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic [31:0]                push_data,
  input  logic                       pop,
  output logic [PW-1:0]              head,
  output logic [PW:0]                count,
  output logic [DEPTH-1:0][AW-1:0]   ent_addr,
  output logic [DEPTH-1:0][31:0]     ent_data
);

  logic [PW-1:0] tail;

  // Power-of-two depth lets pointers wrap
  // naturally on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ent_addr <= '0;
      ent_data <= '0;
    end else begin
      if (push) begin
        ent_addr[tail] <= push_addr;
        ent_data[tail] <= push_data;
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count
             + (PW+1)'(push)
             - (PW+1)'(pop);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: hit compare, memory port arbitration
// and fence FSM. Define STORE_BUFFER_FWD_EN to forward.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cpu_mem_inst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_fence,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic [1:0]  mem_inst,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]            addr_w;
  logic                     unused_addr;
  logic                     push;
  logic                     pop;
  logic [PW-1:0]            head;
  logic [PW:0]              count;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][31:0]   ent_data;
  logic                     full;
  logic                     empty;
  logic                     is_st;
  logic                     is_ld;
  logic                     hit;
  logic [PW-1:0]            idx;
  logic                     stall;
  logic                     rd_mem;
  logic [31:0]              rdata;
  sb_state_e                state;
  sb_state_e                nxt;
`ifdef STORE_BUFFER_FWD_EN
  logic [31:0]              fwd_data;
`endif

  assign addr_w      = cpu_addr[AW-1:0];
  assign unused_addr = ^cpu_addr[31:AW];
  assign full        = count == (PW+1)'(DEPTH);
  assign empty       = count == '0;

  sb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (addr_w),
    .push_data (cpu_wdata),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  always_comb begin
    is_st = 1'b0;
    is_ld = 1'b0;
    unique case (cpu_mem_inst)
      MEM_WRITE: is_st = 1'b1;
      MEM_READ:  is_ld = 1'b1;
      default:   ;
    endcase
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef STORE_BUFFER_FWD_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((PW+1)'(k) < count &&
          ent_addr[idx] == addr_w) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        fwd_data = ent_data[idx];
`endif
      end
    end
  end

  always_comb begin
    stall  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    rd_mem = 1'b0;
    rdata  = '0;
    nxt    = state;
    if (state == FENCE) begin
      stall = 1'b1;
      pop   = !empty;
      if (count == (PW+1)'(1)) nxt = RUN;
    end else if (cpu_fence && !empty) begin
      stall = 1'b1;
      pop   = 1'b1;
      if (count != (PW+1)'(1)) nxt = FENCE;
    end else if (is_ld && hit) begin
`ifdef STORE_BUFFER_FWD_EN
      rdata = fwd_data;
`else
      stall = 1'b1;
`endif
      pop = 1'b1;
    end else if (is_ld) begin
      rd_mem = 1'b1;
      rdata  = mem_data_out;
    end else if (is_st && full) begin
      stall = 1'b1;
      pop   = 1'b1;
    end else begin
      push = is_st;
      pop  = !empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= nxt;
  end

  // Reset gates every output so nothing leaks
  // to memory while rst_n is low.
  always_comb begin
    cpu_stall   = 1'b0;
    cpu_rdata   = '0;
    mem_inst    = MEM_NONE;
    mem_addr    = '0;
    mem_data_in = '0;
    if (rst_n) begin
      cpu_stall = stall;
      cpu_rdata = rdata;
      if (rd_mem) begin
        mem_inst = MEM_READ;
        mem_addr = 32'(addr_w);
      end else if (pop) begin
        mem_inst    = MEM_WRITE;
        mem_addr    = 32'(ent_addr[head]);
        mem_data_in = ent_data[head];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: random CPU traffic checked
// against a program-order memory model.
module tb_store_buffer;
  import sb_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 12;
  localparam int NW    = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cpu_mem_inst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_fence;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic [1:0]  mem_inst;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  logic [31:0] mem     [NW];
  logic [31:0] ref_mem [NW];
  logic [63:0] wq[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_data_out = mem[mem_addr[AW-1:0]];

  store_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_mem_inst (cpu_mem_inst),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_fence    (cpu_fence),
    .cpu_stall    (cpu_stall),
    .cpu_rdata    (cpu_rdata),
    .mem_inst     (mem_inst),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // Every write must be the oldest store not
  // yet seen at the memory port.
  task automatic monitor();
    if (mem_inst == MEM_WRITE) begin
      if (wq.size() == 0)
        chk("wr_unexpected", 64'(wq.size()), 64'd1);
      else
        chk("wr_order", {mem_addr, mem_data_in},
            wq.pop_front());
      mem[mem_addr[AW-1:0]] = mem_data_in;
    end
  endtask

  task automatic drive(input logic [1:0]  inst,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic        f);
    cpu_mem_inst = inst;
    cpu_addr     = a;
    cpu_wdata    = d;
    cpu_fence    = f;
  endtask

  task automatic idle(input int n);
    drive(MEM_NONE, 0, 0, 1'b0);
    repeat (n) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0]  inst,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic        f,
                       output int         stalls);
    logic [AW-1:0] la;
    int            fstart;
    la     = a[AW-1:0];
    fstart = wq.size();
    stalls = 0;
    drive(inst, a, d, f);
    forever begin
      @(negedge clk);
      if (!cpu_stall) begin
        if (inst == MEM_READ)
          chk("ld_data", 64'(cpu_rdata),
              64'(ref_mem[la]));
        monitor();
        if (inst == MEM_WRITE) begin
          ref_mem[la] = d;
          wq.push_back({32'(la), d});
        end
        if (f) begin
          chk("fence_empty", 64'(wq.size()), 64'd0);
          chk("fence_stall", 64'(stalls),
              64'(fstart));
        end
        break;
      end
      monitor();
      stalls++;
      if (stalls > 64) begin
        chk("req_timeout", 64'(stalls), 64'd64);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    drive(MEM_NONE, 0, 0, 1'b0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_stall"}, 64'(cpu_stall), 64'd0);
    chk({tag, "_rdata"}, 64'(cpu_rdata), 64'd0);
    chk({tag, "_minst"}, 64'(mem_inst), 64'd0);
    chk({tag, "_maddr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mdata"}, 64'(mem_data_in), 64'd0);
  endtask

  initial begin
    int          st;
    int          r;
    logic [31:0] old;
    logic [31:0] a;
    logic [31:0] d;

    for (int i = 0; i < NW; i++) begin
      mem[i]     = 32'hA500_0000 ^ (i * 32'h0001_0003);
      ref_mem[i] = mem[i];
    end

    drive(MEM_READ, 32'h14, 0, 1'b0);
    #12;
    chk_reset_outs("rst_ld");
    drive(MEM_WRITE, 32'h4, 32'h1234, 1'b1);
    #10;
    chk_reset_outs("rst_st");
    drive(MEM_NONE, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(MEM_WRITE, 32'h4, 32'h00f0_00f0, 1'b0, st);
    @(negedge clk);
    chk("t1_minst", 64'(mem_inst), 64'(MEM_WRITE));
    chk("t1_maddr", 64'(mem_addr), 64'h4);
    chk("t1_mdata", 64'(mem_data_in), 64'h00f0_00f0);
    monitor();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t1_idle", 64'(mem_inst), 64'(MEM_NONE));
    monitor();
    @(posedge clk);
    #1;

    issue(MEM_WRITE, 32'h40, 32'h0000_1234, 1'b0, st);
    drive(MEM_READ, 32'd20, 0, 1'b0);
    @(negedge clk);
    chk("miss_minst", 64'(mem_inst), 64'(MEM_READ));
    chk("miss_maddr", 64'(mem_addr), 64'd20);
    chk("miss_rdata", 64'(cpu_rdata),
        64'(ref_mem[20]));
    chk("miss_stall", 64'(cpu_stall), 64'd0);
    monitor();
    @(posedge clk);
    #1;
    idle(2);

    issue(MEM_WRITE, 32'h8, 32'h1111_1111, 1'b0, st);
    issue(MEM_WRITE, 32'h8, 32'h2222_2222, 1'b0, st);
    issue(MEM_READ,  32'h8, 0, 1'b0, st);
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_stall", 64'(st), 64'd0);
`else
    chk("hit_stall", 64'(st), 64'd1);
`endif
    chk("hit_value", 64'(ref_mem[8]), 64'h2222_2222);
    idle(2);

    issue(MEM_WRITE, 32'h10, 32'hAAAA_0001, 1'b0, st);
    issue(MEM_WRITE, 32'h11, 32'hAAAA_0002, 1'b0, st);
    issue(MEM_WRITE, 32'h12, 32'hAAAA_0003, 1'b0, st);
    issue(MEM_NONE, 0, 0, 1'b1, st);
    issue(MEM_NONE, 0, 0, 1'b1, st);
    chk("fence_idle", 64'(st), 64'd0);

    old = ref_mem[12'h30];
    issue(MEM_WRITE, 32'h30, 32'hDEAD_BEEF, 1'b0, st);
    drive(MEM_NONE, 0, 0, 1'b1);
    @(negedge clk);
    chk("pre_rst_stall", 64'(cpu_stall), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    ref_mem[12'h30] = old;
    wq.delete();
    @(posedge clk);
    #1;
    chk("rst_hold_minst", 64'(mem_inst), 64'd0);
    drive(MEM_NONE, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    chk("rst_discard", 64'(mem[12'h30]), 64'(old));

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      a = (r % 5 == 0) ? $urandom
                       : 32'($urandom_range(0, 7));
      d = $urandom;
      if (r < 40)
        issue(MEM_WRITE, a, d, 1'b0, st);
      else if (r < 80)
        issue(MEM_READ, a, 0, 1'b0, st);
      else if (r < 88)
        issue(MEM_NONE, a, d, 1'b1, st);
      else if (r < 94)
        issue(2'b11, a, d, 1'b0, st);
      else
        idle($urandom_range(1, 3));
    end

    issue(MEM_NONE, 0, 0, 1'b1, st);
    for (int i = 0; i < 8; i++)
      chk("mem_final", 64'(mem[i]), 64'(ref_mem[i]));
    chk("final_q", 64'(wq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
